// File: rtl/vx_alu_sched_pkg.sv
// Shared types and helpers for the ALU issue scheduler.
package vx_alu_sched_pkg;

    // Warp count used when the instantiating context does not override it.
    localparam int NUM_WARPS_DEF = 8;

    // Index width for n items, never narrower than one bit.
    function automatic int up_clog2(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Packet-lock state of the scheduler.
    typedef enum logic {
        SCHED_OPEN = 1'b0,
        SCHED_LOCK = 1'b1
    } sched_state_e;

    // Per-warp branch lock vector and warp id at the default warp count.
    typedef logic [NUM_WARPS_DEF-1:0]                br_lock_vec_t;
    typedef logic [up_clog2(NUM_WARPS_DEF)-1:0]      wid_t;

endpackage

// File: rtl/vx_alu_sched_arb.sv
// Round-robin grant selection. The pointer only moves when the caller
// signals the end of an instruction, so multi-packet instructions keep
// their priority slot.
module vx_alu_sched_arb
    import vx_alu_sched_pkg::*;
#(
    parameter int  NUM_REQS = 4,
    localparam int IDXW     = up_clog2(NUM_REQS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQS-1:0] req_mask,
    input  logic                advance,
    output logic                grant_vld,
    output logic [IDXW-1:0]     grant_idx
);

    logic [IDXW-1:0] ptr_q, ptr_d;
    logic [IDXW-1:0] cand;

    // Pick the first eligible requester at or after the pointer.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        cand      = '0;
        for (int k = NUM_REQS - 1; k >= 0; k--) begin
            cand = IDXW'((int'(ptr_q) + k) % NUM_REQS);
            if (req_mask[cand]) begin
                grant_vld = 1'b1;
                grant_idx = cand;
            end
        end
    end

    // Move the pointer just past the requester that finished an instruction.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            if (int'(grant_idx) == NUM_REQS - 1) ptr_d = '0;
            else                                 ptr_d = grant_idx + IDXW'(1);
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (reset) ptr_q <= '0;
        else       ptr_q <= ptr_d;
    end

endmodule

// File: rtl/vx_alu_sched.sv
// ALU issue scheduler: arbitrates NUM_REQS requesters onto one ALU port
// through a 2-entry output buffer. Optional per-warp branch locking is
// compiled in with macro ALU_SCHED_BR_LOCK_EN.
//
//   state      | meaning
//   SCHED_OPEN | no instruction in flight, any eligible requester may win
//   SCHED_LOCK | lock_idx_q is mid-instruction and owns the grant until eop
module vx_alu_sched
    import vx_alu_sched_pkg::*;
#(
    parameter int  NUM_REQS  = 4,
    parameter int  DATAW     = 256,
    parameter int  NUM_WARPS = NUM_WARPS_DEF,
    localparam int NW_WIDTH  = up_clog2(NUM_WARPS),
    localparam int IDXW      = up_clog2(NUM_REQS)
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [NUM_REQS-1:0]               req_valid,
    input  logic [NUM_REQS-1:0][DATAW-1:0]    req_data,
    input  logic [NUM_REQS-1:0][NW_WIDTH-1:0] req_wid,
    input  logic [NUM_REQS-1:0]               req_is_br,
    input  logic [NUM_REQS-1:0]               req_sop,
    input  logic [NUM_REQS-1:0]               req_eop,
    output logic [NUM_REQS-1:0]               req_ready,
    output logic                              alu_valid,
    output logic [DATAW-1:0]                  alu_data,
    input  logic                              alu_ready,
    input  logic                              br_valid,
    input  logic [NW_WIDTH-1:0]               br_wid,
    output logic [NUM_WARPS-1:0]              br_pending
);

    sched_state_e        state_q, state_d;
    logic [IDXW-1:0]     lock_idx_q, lock_idx_d;
    logic [NUM_REQS-1:0] req_block;
    logic [NUM_REQS-1:0] req_elig;
    logic                grant_vld;
    logic [IDXW-1:0]     grant_idx;
    logic                buf_rdy;
    logic                fire;
    logic [DATAW-1:0]    sel_data;
    logic [NW_WIDTH-1:0] sel_wid;
    logic                sel_is_br, sel_sop, sel_eop;
    logic                main_vld_q, main_vld_d;
    logic [DATAW-1:0]    main_data_q, main_data_d;
    logic                skid_vld_q, skid_vld_d;
    logic [DATAW-1:0]    skid_data_q, skid_data_d;

    assign sel_data  = req_data[grant_idx];
    assign sel_wid   = req_wid[grant_idx];
    assign sel_is_br = req_is_br[grant_idx];
    assign sel_sop   = req_sop[grant_idx];
    assign sel_eop   = req_eop[grant_idx];

`ifdef ALU_SCHED_BR_LOCK_EN
    logic [NUM_WARPS-1:0] br_pending_q, br_pending_d;

    // Release the resolved warp first so a same-cycle new branch re-locks it.
    always_comb begin
        br_pending_d = br_pending_q;
        if (br_valid) br_pending_d[br_wid] = 1'b0;
        if (fire && sel_is_br && sel_eop) br_pending_d[sel_wid] = 1'b1;
    end

    // Branch lock register.
    always_ff @(posedge clk) begin
        if (reset) br_pending_q <= '0;
        else       br_pending_q <= br_pending_d;
    end

    // A requester whose warp waits on a branch stays out of arbitration.
    always_comb begin
        req_block = '0;
        for (int i = 0; i < NUM_REQS; i++) req_block[i] = br_pending_q[req_wid[i]];
    end

    assign br_pending = br_pending_q;
`else
    logic unused_br;
    assign unused_br  = ^{br_valid, br_wid, sel_is_br, sel_wid};
    assign req_block  = '0;
    assign br_pending = '0;
`endif

    // While locked only the owner competes, and warp locks do not apply to it.
    always_comb begin
        req_elig = '0;
        for (int i = 0; i < NUM_REQS; i++) begin
            if (state_q == SCHED_LOCK) req_elig[i] = req_valid[i] && (lock_idx_q == IDXW'(i));
            else                       req_elig[i] = req_valid[i] && !req_block[i];
        end
    end

    vx_alu_sched_arb #(
        .NUM_REQS (NUM_REQS)
    ) u_arb (
        .clk       (clk),
        .reset     (reset),
        .req_mask  (req_elig),
        .advance   (fire && sel_eop),
        .grant_vld (grant_vld),
        .grant_idx (grant_idx)
    );

    assign fire = grant_vld && buf_rdy && !reset;

    // Ready goes only to the granted requester, never during reset.
    always_comb begin
        req_ready = '0;
        if (fire) req_ready[grant_idx] = 1'b1;
    end

    // Packet lock: enter on a sop without eop, leave on the owner's eop.
    always_comb begin
        state_d    = state_q;
        lock_idx_d = lock_idx_q;
        case (state_q)
            SCHED_OPEN: begin
                if (fire && sel_sop && !sel_eop) begin
                    state_d    = SCHED_LOCK;
                    lock_idx_d = grant_idx;
                end
            end
            SCHED_LOCK: begin
                if (fire && sel_eop) state_d = SCHED_OPEN;
            end
            default: state_d = SCHED_OPEN;
        endcase
    end

    // Scheduler state register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= SCHED_OPEN;
            lock_idx_q <= '0;
        end else begin
            state_q    <= state_d;
            lock_idx_q <= lock_idx_d;
        end
    end

    // Input side stays open while the skid slot is free, so the ready path
    // never depends combinationally on alu_ready.
    assign buf_rdy = !skid_vld_q;

    // Output slot holds under backpressure; a packet arriving then goes to skid.
    always_comb begin
        main_vld_d  = main_vld_q;
        main_data_d = main_data_q;
        skid_vld_d  = skid_vld_q;
        skid_data_d = skid_data_q;
        if (main_vld_q && !alu_ready) begin
            if (fire) begin
                skid_vld_d  = 1'b1;
                skid_data_d = sel_data;
            end
        end else if (skid_vld_q) begin
            main_vld_d  = 1'b1;
            main_data_d = skid_data_q;
            skid_vld_d  = 1'b0;
        end else begin
            main_vld_d = fire;
            if (fire) main_data_d = sel_data;
        end
    end

    // Output buffer registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            main_vld_q  <= 1'b0;
            main_data_q <= '0;
            skid_vld_q  <= 1'b0;
            skid_data_q <= '0;
        end else begin
            main_vld_q  <= main_vld_d;
            main_data_q <= main_data_d;
            skid_vld_q  <= skid_vld_d;
            skid_data_q <= skid_data_d;
        end
    end

    assign alu_valid = main_vld_q;
    assign alu_data  = main_data_q;

endmodule

// File: tb/tb_vx_alu_sched.sv
`timescale 1ns/1ps
module tb_vx_alu_sched;

    localparam int NUM_REQS  = 4;
    localparam int DATAW     = 32;
    localparam int NUM_WARPS = 8;
    localparam int NW        = 3;

    typedef struct packed {
        logic [DATAW-1:0] data;
        logic [NW-1:0]    wid;
        logic             is_br;
        logic             sop;
        logic             eop;
    } pkt_t;

    logic                        clk = 1'b0;
    logic                        reset;
    logic [NUM_REQS-1:0]         req_valid;
    logic [NUM_REQS-1:0][DATAW-1:0] req_data;
    logic [NUM_REQS-1:0][NW-1:0] req_wid;
    logic [NUM_REQS-1:0]         req_is_br;
    logic [NUM_REQS-1:0]         req_sop;
    logic [NUM_REQS-1:0]         req_eop;
    logic [NUM_REQS-1:0]         req_ready;
    logic                        alu_valid;
    logic [DATAW-1:0]            alu_data;
    logic                        alu_ready;
    logic                        br_valid;
    logic [NW-1:0]               br_wid;
    logic [NUM_WARPS-1:0]        br_pending;

    always #5 clk = ~clk;

    vx_alu_sched #(
        .NUM_REQS  (NUM_REQS),
        .DATAW     (DATAW),
        .NUM_WARPS (NUM_WARPS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_wid    (req_wid),
        .req_is_br  (req_is_br),
        .req_sop    (req_sop),
        .req_eop    (req_eop),
        .req_ready  (req_ready),
        .alu_valid  (alu_valid),
        .alu_data   (alu_data),
        .alu_ready  (alu_ready),
        .br_valid   (br_valid),
        .br_wid     (br_wid),
        .br_pending (br_pending)
    );

    int checks   = 0;
    int failures = 0;

    pkt_t                txq [NUM_REQS][$];
    logic [DATAW-1:0]    exp_q[$];
    int                  grant_log[$];
    logic [NUM_REQS-1:0] fired_mask = '0;
    int                  ar_cfg = 1;
    int                  br_cfg = 0;
    bit                  gap_en = 1'b0;
    int                  seq_cnt = 0;

    // reference model state
    int                   m_ptr    = 0;
    bit                   m_locked = 1'b0;
    int                   m_lock   = 0;
    logic [NUM_WARPS-1:0] m_pend   = '0;
    int                   m_occ    = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int pick();
        for (int k = 0; k < NUM_REQS; k++) begin
            int i;
            i = (m_ptr + k) % NUM_REQS;
            if (req_valid[i]) begin
                if (m_locked) begin
                    if (i == m_lock) return i;
                end else if (!m_pend[req_wid[i]]) begin
                    return i;
                end
            end
        end
        return -1;
    endfunction

    function automatic int log_at(input int k);
        if (k < grant_log.size()) return grant_log[k];
        return -2;
    endfunction

    // Monitor: every presented output must be the oldest expected packet.
    initial begin
        @(posedge clk);
        forever begin
            @(negedge clk);
            check("alu_valid", 64'(alu_valid), 64'(exp_q.size() > 0));
            if (alu_valid && exp_q.size() > 0) begin
                check("alu_data", 64'(alu_data), 64'(exp_q[0]));
                if (alu_ready) void'(exp_q.pop_front());
            end
        end
    end

    // Reference model: predicts the grant and feeds the scoreboard.
    initial begin
        int gi, g;
        bit fire, consumed;
        logic [NUM_REQS-1:0] exp_rdy;
        @(posedge clk);
        forever begin
            @(negedge clk); #1;
            fired_mask = req_valid & req_ready;
            gi = -1;
            for (int i = 0; i < NUM_REQS; i++)
                if (fired_mask[i]) gi = (gi == -1) ? i : 99;
            grant_log.push_back(gi);
            g = pick();
            fire = !reset && (m_occ < 2) && (g >= 0);
            exp_rdy = '0;
            if (fire) exp_rdy[g] = 1'b1;
            check("req_ready", 64'(req_ready), 64'(exp_rdy));
            check("br_pending", 64'(br_pending), 64'(m_pend));
            if (reset) begin
                m_ptr = 0; m_locked = 1'b0; m_lock = 0; m_pend = '0; m_occ = 0;
                exp_q.delete();
            end else begin
                consumed = (m_occ > 0) && alu_ready;
`ifdef ALU_SCHED_BR_LOCK_EN
                if (br_valid) m_pend[br_wid] = 1'b0;
                if (fire && req_is_br[g] && req_eop[g]) m_pend[req_wid[g]] = 1'b1;
`endif
                if (fire) begin
                    exp_q.push_back(req_data[g]);
                    if (req_eop[g]) begin
                        m_locked = 1'b0;
                        m_ptr = (g + 1) % NUM_REQS;
                    end else if (req_sop[g]) begin
                        m_locked = 1'b1;
                        m_lock = g;
                    end
                end
                m_occ = m_occ + int'(fire) - int'(consumed);
            end
        end
    end

    task automatic push_instr(input int r, input int len, input int wid, input bit is_br);
        pkt_t p;
        for (int n = 0; n < len; n++) begin
            p.data  = {8'(r), 8'(seq_cnt), 16'($urandom)};
            p.wid   = NW'(wid);
            p.is_br = is_br;
            p.sop   = (n == 0);
            p.eop   = (n == len - 1);
            seq_cnt++;
            txq[r].push_back(p);
        end
    endtask

    task automatic step();
        pkt_t p;
        @(posedge clk); #1;
        for (int i = 0; i < NUM_REQS; i++)
            if (fired_mask[i] && txq[i].size() > 0) void'(txq[i].pop_front());
        for (int i = 0; i < NUM_REQS; i++) begin
            if (txq[i].size() > 0 && (!gap_en || $urandom_range(0, 3) != 0)) begin
                p = txq[i][0];
                req_valid[i] = 1'b1;
                req_data[i]  = p.data;
                req_wid[i]   = p.wid;
                req_is_br[i] = p.is_br;
                req_sop[i]   = p.sop;
                req_eop[i]   = p.eop;
            end else begin
                req_valid[i] = 1'b0;
                req_data[i]  = '0;
                req_wid[i]   = '0;
                req_is_br[i] = 1'b0;
                req_sop[i]   = 1'b0;
                req_eop[i]   = 1'b0;
            end
        end
        case (ar_cfg)
            0:       alu_ready = 1'b0;
            1:       alu_ready = 1'b1;
            default: alu_ready = ($urandom_range(0, 3) != 0);
        endcase
        case (br_cfg)
            0:       begin br_valid = 1'b0; br_wid = '0; end
            1:       begin br_valid = ($urandom_range(0, 3) == 0); br_wid = NW'($urandom_range(0, 7)); end
            default: begin br_valid = 1'b1; br_wid = NW'(5); end
        endcase
    endtask

    // Advance one cycle so the newly presented cycle is the first log entry.
    task automatic start_log();
        step();
        grant_log.delete();
    endtask

    function automatic bit busy();
        for (int i = 0; i < NUM_REQS; i++) if (txq[i].size() > 0) return 1'b1;
        return (exp_q.size() > 0) || (m_occ > 0);
    endfunction

    task automatic drain(input string name);
        int n;
        n = 0;
        while (busy() && n < 500) begin
            step();
            n++;
        end
        check(name, 64'(busy()), 64'(0));
    endtask

    initial begin
        int nf;
        reset = 1'b1;
        req_valid = '0; req_data = '0; req_wid = '0;
        req_is_br = '0; req_sop = '0; req_eop = '0;
        alu_ready = 1'b1; br_valid = 1'b0; br_wid = '0;
        repeat (3) step();
        reset = 1'b0;

        // Four single-packet requesters after reset: 0,1,2,3,0.
        for (int r = 0; r < NUM_REQS; r++) push_instr(r, 1, r, 1'b0);
        push_instr(0, 1, 0, 1'b0);
        start_log();
        repeat (6) step();
        check("rr_grant0", 64'(log_at(0)), 64'(0));
        check("rr_grant1", 64'(log_at(1)), 64'(1));
        check("rr_grant2", 64'(log_at(2)), 64'(2));
        check("rr_grant3", 64'(log_at(3)), 64'(3));
        check("rr_grant4", 64'(log_at(4)), 64'(0));
        drain("drain_rr");

        // Backpressure: two packets accepted, then nothing until it lifts.
        for (int r = 0; r < NUM_REQS; r++) begin
            push_instr(r, 1, r, 1'b0);
            push_instr(r, 1, r, 1'b0);
        end
        ar_cfg = 0;
        start_log();
        repeat (3) step();
        ar_cfg = 1;
        step();
        nf = 0;
        for (int k = 0; k < 4; k++) if (log_at(k) >= 0) nf++;
        check("stall_fires", 64'(nf), 64'(2));
        check("stall_late_fire", 64'(log_at(3)), 64'(-1));
        drain("drain_stall");

        // Pointer sits at 1: req1's 3-packet instruction, then req2, req0.
        push_instr(0, 1, 0, 1'b0);
        push_instr(1, 3, 1, 1'b0);
        push_instr(2, 1, 2, 1'b0);
        start_log();
        repeat (6) step();
        check("pkt_lock0", 64'(log_at(0)), 64'(1));
        check("pkt_lock1", 64'(log_at(1)), 64'(1));
        check("pkt_lock2", 64'(log_at(2)), 64'(1));
        check("pkt_after3", 64'(log_at(3)), 64'(2));
        check("pkt_after4", 64'(log_at(4)), 64'(0));
        drain("drain_pkt");

        // Branch on warp 5 followed by another warp-5 packet from req0.
        push_instr(0, 1, 5, 1'b1);
        push_instr(0, 1, 5, 1'b0);
        br_cfg = 0;
        start_log();
        repeat (2) step();
        br_cfg = 2;
        step();
        br_cfg = 0;
        repeat (2) step();
`ifdef ALU_SCHED_BR_LOCK_EN
        check("br_seq0", 64'(log_at(0)), 64'(0));
        check("br_seq1", 64'(log_at(1)), 64'(-1));
        check("br_seq3", 64'(log_at(3)), 64'(-1));
        check("br_seq4", 64'(log_at(4)), 64'(0));
`else
        check("br_seq0", 64'(log_at(0)), 64'(0));
        check("br_seq1", 64'(log_at(1)), 64'(0));
        check("br_seq4", 64'(log_at(4)), 64'(-1));
`endif
        drain("drain_br");

        // Reset in the middle of req2's instruction.
        push_instr(2, 3, 4, 1'b1);
        start_log();
        step();
        reset = 1'b1;
        for (int r = 0; r < NUM_REQS; r++) txq[r].delete();
        step();
        check("rst_alu_valid", 64'(alu_valid), 64'(0));
        check("rst_br_pending", 64'(br_pending), 64'(0));
        step();
        reset = 1'b0;
        for (int r = NUM_REQS - 1; r >= 0; r--) push_instr(r, 1, r, 1'b0);
        start_log();
        repeat (2) step();
        check("rst_first_grant", 64'(log_at(0)), 64'(0));
        drain("drain_rst");

        // Randomized traffic with gaps, backpressure and branch resolves.
        gap_en = 1'b1; ar_cfg = 2; br_cfg = 1;
        for (int c = 0; c < 800; c++) begin
            for (int r = 0; r < NUM_REQS; r++)
                if (txq[r].size() < 3 && $urandom_range(0, 2) == 0)
                    push_instr(r, $urandom_range(1, 3), $urandom_range(0, 7), ($urandom_range(0, 3) == 0));
            if (c == 400) begin
                reset = 1'b1;
                for (int r = 0; r < NUM_REQS; r++) txq[r].delete();
                repeat (2) step();
                reset = 1'b0;
            end
            step();
        end
        gap_en = 1'b0; ar_cfg = 1;
        drain("drain_random");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
